// File: rtl/pll_sched_pkg.sv
// Shared types and constants for the PLL dynamic phase-step scheduler.
// Imported by the scheduler top and its scanclk generator.
package pll_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ASSERT,
        RELEASE,
        WAITDONE,
        FINISH
    } state_t;

    localparam logic [2:0] SEL_ALL = 3'b000;
    localparam logic [2:0] SEL_M   = 3'b001;
    localparam logic [2:0] SEL_C0  = 3'b010;
    localparam logic [2:0] SEL_C1  = 3'b011;
    localparam logic [2:0] SEL_C2  = 3'b100;
    localparam logic [2:0] SEL_C3  = 3'b101;
    localparam logic [2:0] SEL_C4  = 3'b110;

    localparam int DEF_SC_HALF    = 16;
    localparam int DEF_TIMEOUT_SC = 100;

endpackage

// File: rtl/pll_scanclk_gen.sv
// Divided scan clock for the PLL reconfiguration port.
// Strobes flag the clk edge on which scanclk is about to rise or fall.
module pll_scanclk_gen
    import pll_sched_pkg::*;
#(
    parameter int SC_HALF = DEF_SC_HALF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic scanclk,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(SC_HALF);
    localparam logic [CW-1:0] LAST = CW'(SC_HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          wrap;

    assign wrap = en && (cnt_q == LAST);

    always_comb begin
        cnt_d  = '0;
        sclk_d = 1'b0;
        if (en) begin
            cnt_d  = wrap ? '0 : cnt_q + 1'b1;
            sclk_d = wrap ? ~sclk_q : sclk_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign scanclk = sclk_q;
    assign rise    = wrap && !sclk_q;
    assign fall    = wrap && sclk_q;

endmodule

// File: rtl/pll_phase_scheduler.sv
// Two-requester round-robin scheduler driving PLL dynamic phase steps.
// Each step: phasestep high for two scanclk rises, then wait for phase_done.
module pll_phase_scheduler
    import pll_sched_pkg::*;
#(
    parameter int SC_HALF    = DEF_SC_HALF,
    parameter int TIMEOUT_SC = DEF_TIMEOUT_SC
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_valid,
    input  logic [5:0] req_sel,
    input  logic [1:0] req_up,
    input  logic [7:0] req_steps,
    output logic [1:0] req_ack,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       owner,
    output logic [2:0] phasecounterselect,
    output logic       phaseupdown,
    output logic       phasestep,
    output logic       scanclk,
    input  logic       phase_done
);

    localparam int TW = $clog2(TIMEOUT_SC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_SC - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_SC);

    state_t        state_q, state_d;
    logic [2:0]    sel_q, sel_d;
    logic          up_q, up_d;
    logic [3:0]    steps_q, steps_d;
    logic          edge_q, edge_d;
    logic [TW-1:0] to_q, to_d;
    logic          seen_low_q, seen_low_d;
    logic          phasestep_q, phasestep_d;
    logic [1:0]    ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          owner_q, owner_d;
    logic          prio_q, prio_d;
    logic          pd_s1_q, pd_s1_d;
    logic          pd_s2_q, pd_s2_d;

    logic sc_en, sc_rise, sc_fall, win;

    // First ASSERT cycle keeps the divider cleared so every step starts low.
    assign sc_en = (state_q == ASSERT && phasestep_q)
                || state_q == RELEASE
                || state_q == WAITDONE;

    pll_scanclk_gen #(.SC_HALF(SC_HALF)) u_sc (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (sc_en),
        .scanclk (scanclk),
        .rise    (sc_rise),
        .fall    (sc_fall)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        up_d        = up_q;
        steps_d     = steps_q;
        edge_d      = edge_q;
        to_d        = to_q;
        seen_low_d  = seen_low_q;
        phasestep_d = phasestep_q;
        ack_d       = 2'b00;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        owner_d     = owner_q;
        prio_d      = prio_q;
        pd_s1_d     = phase_done;
        pd_s2_d     = pd_s1_q;
        win         = (req_valid == 2'b11) ? prio_q : req_valid[1];

        unique case (state_q)
            IDLE: begin
                if ((|req_valid) && !done_q && !err_q) begin
                    ack_d   = win ? 2'b10 : 2'b01;
                    owner_d = win;
                    prio_d  = ~win;
                    sel_d   = win ? req_sel[5:3] : req_sel[2:0];
                    up_d    = req_up[win];
                    steps_d = win ? req_steps[7:4] : req_steps[3:0];
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                edge_d  = 1'b0;
                state_d = (steps_q == 4'd0) ? FINISH : ASSERT;
            end
            ASSERT: begin
                phasestep_d = 1'b1;
                if (sc_rise) begin
                    if (edge_q) state_d = RELEASE;
                    else        edge_d  = 1'b1;
                end
            end
            RELEASE: begin
                if (sc_fall) begin
                    phasestep_d = 1'b0;
                    seen_low_d  = 1'b0;
                    to_d        = '0;
                    state_d     = WAITDONE;
                end
            end
            WAITDONE: begin
                if (!pd_s2_q) seen_low_d = 1'b1;
                if (seen_low_q && pd_s2_q) begin
                    steps_d = (steps_q != 4'd0) ? steps_q - 4'd1 : steps_q;
                    edge_d  = 1'b0;
                    state_d = (steps_q <= 4'd1) ? FINISH : ASSERT;
                end else if (sc_rise) begin
                    to_d = (to_q == TO_MAX) ? to_q : to_q + 1'b1;
                    if (to_q == TO_LAST) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sel_q       <= 3'b000;
            up_q        <= 1'b1;
            steps_q     <= '0;
            edge_q      <= 1'b0;
            to_q        <= '0;
            seen_low_q  <= 1'b0;
            phasestep_q <= 1'b0;
            ack_q       <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            owner_q     <= 1'b0;
            prio_q      <= 1'b0;
            pd_s1_q     <= 1'b0;
            pd_s2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            up_q        <= up_d;
            steps_q     <= steps_d;
            edge_q      <= edge_d;
            to_q        <= to_d;
            seen_low_q  <= seen_low_d;
            phasestep_q <= phasestep_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            owner_q     <= owner_d;
            prio_q      <= prio_d;
            pd_s1_q     <= pd_s1_d;
            pd_s2_q     <= pd_s2_d;
        end
    end

    assign req_ack            = ack_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;
    assign owner              = owner_q;
    assign phasecounterselect = sel_q;
    assign phaseupdown        = up_q;
    assign phasestep          = phasestep_q;

endmodule
